// File: rtl/lsu.sv
// lsu: load/store unit between the execute stage and the data-memory port.
// Accepts one request at a time, aligns address/data/byte mask for stores,
// extracts and extends load data, and rejects misaligned or illegal-size
// accesses without issuing a memory request.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           core request handshake
//   req_wen, req_size, req_signed request type, size (00 b, 01 h, 10 w), extension
//   req_addr, req_wdata           byte address, right-justified store data
//   mem_ren/mem_wen               memory read/write request (held until mem_gnt)
//   mem_raddr/mem_waddr           word-aligned addresses, 0 when not requesting
//   mem_wdata, mem_wmask          lane-shifted store data and byte-lane mask
//   mem_gnt, mem_rvalid, mem_rdata, mem_bvalid   memory handshake and read data
//   resp_valid, resp_rdata, resp_err             one-cycle completion to the core
module lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_bvalid,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                wen_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                illegal;
  logic                rsp_match;
  logic                capture;
  logic [4:0]          lane_shift;
  logic [3:0]          mask4;
  logic [DATA_W-1:0]   rshift;
  logic [DATA_W-1:0]   load_ext;
  logic [ADDR_W-1:0]   word_addr;

  assign illegal = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && (req_addr[1:0] != 2'b00));

  // Only the response type matching the latched request counts.
  assign rsp_match = wen_q ? mem_bvalid : mem_rvalid;

  assign capture = !wen_q && mem_rvalid &&
                   ((state_q == StReq && mem_gnt) || state_q == StWait);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wen_q    <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        wen_q    <= req_wen;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= illegal;
      end
      if (capture) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) state_d = illegal ? StResp : StReq;
      StReq:  if (mem_gnt) state_d = rsp_match ? StResp : StWait;
      StWait: if (rsp_match) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath helpers: lane shift is 8 * addr[1:0].
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    word_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    unique case (size_q)
      2'b00:   mask4 = 4'b0001 << addr_q[1:0];
      2'b01:   mask4 = 4'b0011 << addr_q[1:0];
      default: mask4 = 4'b1111;
    endcase
    rshift = rdata_q >> lane_shift;
    unique case (size_q)
      2'b00:   load_ext = {{(DATA_W-8){signed_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_ext = {{(DATA_W-16){signed_q & rshift[15]}}, rshift[15:0]};
      default: load_ext = rshift;
    endcase
  end

  // Output decode from registered state and latched request
  always_comb begin
    req_ready  = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_raddr  = '0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StReq: begin
        if (wen_q) begin
          mem_wen   = 1'b1;
          mem_waddr = word_addr;
          mem_wdata = wdata_q << lane_shift;
          mem_wmask = {4'b0000, mask4};
        end else begin
          mem_ren   = 1'b1;
          mem_raddr = word_addr;
        end
      end
      StWait: ;
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (wen_q || err_q) ? '0 : load_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_bvalid;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_bvalid (mem_bvalid),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle. Returns at the falling edge of
  // the idle cycle that follows the response, so calls chain back-to-back.
  task automatic access(input logic wen, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rword, input int gnt_wait, input int gap,
                        input logic [31:0] exp_data, input logic exp_err,
                        input logic [31:0] exp_maddr, input logic [31:0] exp_wdata,
                        input logic [7:0] exp_mask);
    exp_t e;
    int   cyc;
    bit   found;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    sb.push_back('{data: exp_data, err: exp_err, lat: exp_err ? 1 : 2 + gnt_wait + gap});
    @(negedge clk);
    cyc = 1;
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_wdata = 32'hDEAD_BEEF;
    if (exp_err) begin
      chk("err_no_mem", {30'b0, mem_ren, mem_wen}, 32'd0);
    end else begin
      for (int i = 0; i <= gnt_wait; i++) begin
        chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
        chk("mem_ren", {31'b0, mem_ren}, {31'b0, !wen});
        chk("mem_wen", {31'b0, mem_wen}, {31'b0, wen});
        chk("mem_raddr", mem_raddr, wen ? 32'd0 : exp_maddr);
        chk("mem_waddr", mem_waddr, wen ? exp_maddr : 32'd0);
        if (wen) begin
          chk("mem_wdata", mem_wdata, exp_wdata);
          chk("mem_wmask", {24'b0, mem_wmask}, {24'b0, exp_mask});
        end
        if (i == gnt_wait) begin
          mem_gnt = 1'b1;
          if (gap == 0) begin
            mem_rvalid = !wen;
            mem_bvalid = wen;
            mem_rdata  = rword;
          end
        end
        @(negedge clk);
        cyc++;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_bvalid = 1'b0;
        mem_rdata  = 32'h0;
      end
      for (int j = 1; j <= gap; j++) begin
        chk("wait_no_mem", {30'b0, mem_ren, mem_wen}, 32'd0);
        chk("wait_no_resp", {31'b0, resp_valid}, 32'd0);
        if (j == gap) begin
          mem_rvalid = !wen;
          mem_bvalid = wen;
          mem_rdata  = rword;
        end else begin
          // Response of the wrong type must be ignored.
          mem_rvalid = wen;
          mem_bvalid = !wen;
          mem_rdata  = 32'h5A5A_5A5A;
        end
        @(negedge clk);
        cyc++;
        mem_rvalid = 1'b0;
        mem_bvalid = 1'b0;
        mem_rdata  = 32'h0;
      end
    end
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (resp_valid === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    if (!found) begin
      chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
    end else begin
      chk("resp_latency", cyc, e.lat);
      chk("resp_rdata", resp_rdata, e.data);
      chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
    end
    @(negedge clk);
    chk("resp_single_pulse", {31'b0, resp_valid}, 32'd0);
    chk("req_ready_after", {31'b0, req_ready}, 32'd1);
    chk("idle_no_mem", {30'b0, mem_ren, mem_wen}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    mem_bvalid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_en", {30'b0, mem_ren, mem_wen}, 32'd0);
    chk("rst_mem_raddr", mem_raddr, 32'd0);
    chk("rst_mem_waddr", mem_waddr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wmask", {24'b0, mem_wmask}, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Signed byte load, zero-wait
    access(1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 0, 0,
           32'hFFFF_FF80, 1'b0, 32'h8000_0000, 32'h0, 8'h00);
    // Unsigned half load followed immediately by a word load
    access(1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0, 32'hF00D_1234, 0, 0,
           32'h0000_F00D, 1'b0, 32'h8000_0000, 32'h0, 8'h00);
    access(1'b0, 2'b10, 1'b1, 32'h8000_0004, 32'h0, 32'h1122_3344, 0, 0,
           32'h1122_3344, 1'b0, 32'h8000_0004, 32'h0, 8'h00);
    // Half store with one wait cycle before bvalid
    access(1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 0, 1,
           32'h0, 1'b0, 32'h8000_0000, 32'hABCD_0000, 8'h0C);
    // Illegal requests
    access(1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, 32'h0, 0, 0,
           32'h0, 1'b1, 32'h0, 32'h0, 8'h00);
    access(1'b0, 2'b11, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 0,
           32'h0, 1'b1, 32'h0, 32'h0, 8'h00);
    access(1'b1, 2'b01, 1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 0, 0,
           32'h0, 1'b1, 32'h0, 32'h0, 8'h00);
    // Grant withheld 3 cycles, rvalid the cycle after grant
    access(1'b0, 2'b00, 1'b0, 32'h8000_0011, 32'h0, 32'h1234_5678, 3, 1,
           32'h0000_0056, 1'b0, 32'h8000_0010, 32'h0, 8'h00);
    // Signed half at upper lane, byte store at lane 1 with a stray rvalid in WAIT
    access(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_FFFF, 1, 0,
           32'hFFFF_8001, 1'b0, 32'h0000_0100, 32'h0, 8'h00);
    access(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00EE, 32'h0, 0, 2,
           32'h0, 1'b0, 32'h0000_0200, 32'h0000_EE00, 8'h02);
    // Signed byte with bit 7 clear, word store
    access(1'b0, 2'b00, 1'b1, 32'h0000_0300, 32'h0, 32'hFFFF_FF7F, 0, 0,
           32'h0000_007F, 1'b0, 32'h0000_0300, 32'h0, 8'h00);
    access(1'b1, 2'b10, 1'b0, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 2, 0,
           32'h0, 1'b0, 32'h0000_0404, 32'hCAFE_F00D, 8'h0F);

    // Stray responses while idle
    mem_rvalid = 1'b1;
    mem_bvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_bvalid = 1'b0;
    chk("stray_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("stray_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    chk("stray_no_resp2", {31'b0, resp_valid}, 32'd0);

    // Reset while waiting for read data
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h8000_0008;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw_req_ren", {31'b0, mem_ren}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstw_wait_ren", {31'b0, mem_ren}, 32'd0);
    chk("rstw_wait_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ren", {31'b0, mem_ren}, 32'd0);
    chk("rstw_ready", {31'b0, req_ready}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2222_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rstw_late_rvalid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("rstw_late_rvalid2", {31'b0, resp_valid}, 32'd0);

    // Reset while requesting: the request drops the next cycle
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h8000_000C;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstr_wen", {31'b0, mem_wen}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstr_wen_low", {31'b0, mem_wen}, 32'd0);
    chk("rstr_waddr", mem_waddr, 32'd0);
    chk("rstr_ready", {31'b0, req_ready}, 32'd1);

    // Still functional after reset
    access(1'b0, 2'b00, 1'b0, 32'h8000_0002, 32'h0, 32'hA5B6_C7D8, 0, 0,
           32'h0000_00B6, 1'b0, 32'h8000_0000, 32'h0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
